// File: rtl/rvfi_seq_pkg.sv
// Shared types for the RVFI retirement sequencer: record layout, FSM states,
// sticky error bit positions and a saturating counter helper.
package rvfi_seq_pkg;

  localparam int RvfiPktW = 382;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_retire_t;

  typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} seq_state_e;

  localparam int ErrOvfl     = 0;
  localparam int ErrOrder    = 1;
  localparam int ErrPostHalt = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rvfi_retire_sequencer_if.sv
// Retirement input and consumer handshake bundle; the sequencer uses the
// slave view, the driving environment the master view.
interface rvfi_retire_sequencer_if;
  import rvfi_seq_pkg::*;

  logic         rvfi_valid_i;
  rvfi_retire_t rvfi_pkt_i;
  logic         out_valid_o;
  logic         out_ready_i;
  rvfi_retire_t out_pkt_o;

  modport master (
    output rvfi_valid_i, rvfi_pkt_i, out_ready_i,
    input  out_valid_o, out_pkt_o
  );

  modport slave (
    input  rvfi_valid_i, rvfi_pkt_i, out_ready_i,
    output out_valid_o, out_pkt_o
  );
endinterface

// File: rtl/rvfi_seq_fifo.sv
// Synchronous FIFO whose head is read straight from the storage registers,
// so a write becomes visible the cycle after it is accepted.
module rvfi_seq_fifo #(
  parameter  int DATA_W = 8,
  parameter  int Depth  = 8,
  localparam int AW     = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level
);

  logic [DATA_W-1:0] r_mem [Depth];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(Depth));
  assign o_level   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// Buffers RVFI retirements for a slower consumer, tracks order continuity,
// sequences halt/resume and keeps sticky error/drop bookkeeping.
module rvfi_retire_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter  int          Depth      = 8,
  parameter  logic [63:0] FirstOrder = 64'd0,
  localparam int          LvlW       = $clog2(Depth) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  rvfi_retire_sequencer_if.slave    bus,
  input  logic                      flush_i,
  input  logic                      resume_i,
  output logic                      halted_o,
  output logic [LvlW-1:0]           level_o,
  output logic [15:0]               drop_cnt_o,
  output logic [2:0]                err_o,
  output logic [63:0]               err_order_o
);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic [63:0]         r_exp_order;
  logic [2:0]          r_err;
  logic [63:0]         r_err_order;
  logic [15:0]         r_drop_cnt;
  logic                w_full;
  logic                w_empty;
  logic [LvlW-1:0]     w_level;
  logic [RvfiPktW-1:0] w_head;
  logic                w_rec;
  logic                w_run;
  logic                w_pop;
  logic                w_push;
  logic                w_drop_ovfl;
  logic                w_drop_halt;
  logic                w_order_bad;

  // A record arriving together with flush is discarded without any bookkeeping.
  assign w_rec       = bus.rvfi_valid_i && !flush_i;
  assign w_run       = (r_state == RUN);
  assign w_pop       = !w_empty && bus.out_ready_i;
  assign w_push      = w_rec && w_run && (!w_full || w_pop);
  assign w_drop_ovfl = w_rec && w_run && w_full && !w_pop;
  assign w_drop_halt = w_rec && !w_run;
  assign w_order_bad = w_rec && (bus.rvfi_pkt_i.order != r_exp_order);

  rvfi_seq_fifo #(
    .DATA_W (RvfiPktW),
    .Depth  (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .i_data  (bus.rvfi_pkt_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.out_valid_o = !w_empty;
  assign bus.out_pkt_o   = rvfi_retire_t'(w_head);
  assign halted_o        = (r_state == HALTED);
  assign level_o         = w_level;
  assign drop_cnt_o      = r_drop_cnt;
  assign err_o           = r_err;
  assign err_order_o     = r_err_order;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:        if (w_push && bus.rvfi_pkt_i.halt) w_state_nxt = HALT_DRAIN;
      // Enter HALTED as soon as the last queued record leaves.
      HALT_DRAIN: if (w_empty || (w_pop && w_level == LvlW'(1))) w_state_nxt = HALTED;
      HALTED:     if (resume_i) w_state_nxt = RUN;
      default:    w_state_nxt = RUN;
    endcase
    if (flush_i) w_state_nxt = RUN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_exp_order <= FirstOrder;
      r_err       <= '0;
      r_err_order <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i)    r_exp_order <= FirstOrder;
      else if (w_rec) r_exp_order <= bus.rvfi_pkt_i.order + 64'd1;
      if (w_order_bad) begin
        r_err[ErrOrder] <= 1'b1;
        if (!r_err[ErrOrder]) r_err_order <= bus.rvfi_pkt_i.order;
      end
      if (w_drop_ovfl) r_err[ErrOvfl]     <= 1'b1;
      if (w_drop_halt) r_err[ErrPostHalt] <= 1'b1;
      if (w_drop_ovfl || w_drop_halt) r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// Scoreboard bench for rvfi_retire_sequencer: accepted records are queued at
// drive time and matched against every consumer handshake.
module tb_rvfi_retire_sequencer;
  import rvfi_seq_pkg::*;

  localparam int Depth = 8;
  localparam int LvlW  = $clog2(Depth) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            resume;
  logic            halted;
  logic [LvlW-1:0] level;
  logic [15:0]     drop_cnt;
  logic [2:0]      err;
  logic [63:0]     err_order;

  always #5 clk = ~clk;

  rvfi_retire_sequencer_if bus ();

  rvfi_retire_sequencer #(
    .Depth      (Depth),
    .FirstOrder (64'd0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .flush_i     (flush),
    .resume_i    (resume),
    .halted_o    (halted),
    .level_o     (level),
    .drop_cnt_o  (drop_cnt),
    .err_o       (err),
    .err_order_o (err_order)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] m_exp;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Consumer side: the handshake visible at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && !flush && bus.out_valid_o && bus.out_ready_i) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pop", 64'd1, 64'd0);
      end else begin
        m_exp = sb_q.pop_front();
        chk("out_order", bus.out_pkt_o.order, m_exp);
        chk("out_insn", {32'd0, bus.out_pkt_o.insn}, {32'd0, ~m_exp[31:0]});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [63:0] ord, input logic h, input logic exp_acc);
    rvfi_retire_t p;
    p       = '0;
    p.order = ord;
    p.insn  = ~ord[31:0];
    p.halt  = h;
    bus.rvfi_valid_i = 1'b1;
    bus.rvfi_pkt_i   = p;
    if (exp_acc) sb_q.push_back(ord);
    step(1);
    bus.rvfi_valid_i = 1'b0;
    bus.rvfi_pkt_i   = '0;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    flush            = 1'b0;
    resume           = 1'b0;
    bus.rvfi_valid_i = 1'b0;
    bus.rvfi_pkt_i   = '0;
    bus.out_ready_i  = 1'b0;
    sb_q.delete();
    #3;
    rst = 1'b0;
    step(1);
  endtask

  task automatic drain(input string tag);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1);
    chk(tag, sb_q.size(), 0);
    step(1);
    chk({tag, "_lvl"}, level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: finished got 0 want 1");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_pkt", bus.out_pkt_o.order, 0);
    chk("rst_err", err, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err_order", err_order, 0);

    // Back-to-back with consumer always ready
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      put(64'(i), 1'b0, 1'b1);
      chk("t1_head", bus.out_pkt_o.order, 64'(i));
      chk("t1_lvl_le1", level <= 1, 1);
    end
    step(2);
    chk("t1_err", err, 0);
    chk("t1_lvl", level, 0);

    // Overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 10; i++) put(64'(i), 1'b0, i < 8);
    chk("t2_lvl", level, 8);
    chk("t2_drop", drop_cnt, 2);
    chk("t2_err", err, 3'b001);
    drain("t2_drain");

    // Full FIFO with simultaneous pop
    do_reset();
    for (int i = 0; i < 8; i++) put(64'(i), 1'b0, 1'b1);
    chk("t3_full", level, 8);
    bus.out_ready_i = 1'b1;
    put(64'd8, 1'b0, 1'b1);
    chk("t3_lvl", level, 8);
    chk("t3_err", err, 0);
    chk("t3_drop", drop_cnt, 0);
    drain("t3_drain");

    // Order gap, resync, and first-mismatch capture
    do_reset();
    bus.out_ready_i = 1'b1;
    put(64'd0, 1'b0, 1'b1);
    put(64'd1, 1'b0, 1'b1);
    chk("t4_err_pre", err, 0);
    put(64'd3, 1'b0, 1'b1);
    chk("t4_err", err, 3'b010);
    chk("t4_err_order", err_order, 3);
    put(64'd4, 1'b0, 1'b1);
    chk("t4_err_after", err, 3'b010);
    put(64'd7, 1'b0, 1'b1);
    chk("t4_err_order_first", err_order, 3);
    drain("t4_drain");

    // Halt, post-halt drop, resume
    do_reset();
    put(64'd0, 1'b0, 1'b1);
    put(64'd1, 1'b0, 1'b1);
    put(64'd2, 1'b1, 1'b1);
    step(2);
    chk("t5_not_halted", halted, 0);
    put(64'd3, 1'b0, 1'b0);
    chk("t5_err", err, 3'b100);
    chk("t5_drop", drop_cnt, 1);
    chk("t5_lvl", level, 3);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 20 && !halted; i++) step(1);
    chk("t5_halted", halted, 1);
    chk("t5_sb", sb_q.size(), 0);
    chk("t5_lvl_empty", level, 0);
    put(64'd4, 1'b0, 1'b0);
    chk("t5_drop2", drop_cnt, 2);
    chk("t5_still_halted", halted, 1);
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    chk("t5_resumed", halted, 0);
    put(64'd5, 1'b0, 1'b1);
    chk("t5_err_final", err, 3'b100);
    drain("t5_drain");

    // Flush keeps sticky state and restarts order tracking
    do_reset();
    for (int i = 0; i < 9; i++) put(64'(i), 1'b0, i < 8);
    chk("t6_pre_valid", bus.out_valid_o, 1);
    chk("t6_pre_err", err, 3'b001);
    flush = 1'b1;
    put(64'd9, 1'b0, 1'b0);
    flush = 1'b0;
    sb_q.delete();
    chk("t6_lvl", level, 0);
    chk("t6_valid", bus.out_valid_o, 0);
    chk("t6_err", err, 3'b001);
    chk("t6_drop", drop_cnt, 1);
    bus.out_ready_i = 1'b1;
    put(64'd0, 1'b0, 1'b1);
    chk("t6_head", bus.out_pkt_o.order, 0);
    chk("t6_err_after", err, 3'b001);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_sequencer.md
Name: rvfi_retire_sequencer

Overview:
- Buffers Ibex RVFI retirement records and hands them, strictly in program order, to a slower DV consumer (cosim/scoreboard) over a valid/ready handshake.
- Sits between the core's RVFI probe and the checker. RVFI itself has no backpressure, so this block absorbs bursts.
- Checks order continuity and sequences the halt/resume protocol.
- Flags overflow and protocol errors with sticky bits.

Parameters:
- Depth, 8, FIFO entries; power of two, at least 2.
- FirstOrder, 64'd0, expected rvfi order after reset or flush.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- rvfi_valid_i  in  1  retirement strobe, one record per cycle, no backpressure.
- rvfi_pkt_i  in  382  rvfi_retire_t: order, insn, trap, halt, intr, mode, ixl, rs1/rs2 addr+rdata, rd addr+wdata, pc r/w, mem addr/rmask/wmask/rdata/wdata.
- out_valid_o  out  1  head record available.
- out_ready_i  in  1  consumer accepts the head record.
- out_pkt_o  out  382  head record.
- flush_i  in  1  synchronous clear of FIFO, state and order tracker.
- resume_i  in  1  leave HALTED.
- halted_o  out  1  halt record consumed and FIFO empty.
- level_o  out  $clog2(Depth)+1  current occupancy.
- drop_cnt_o  out  16  dropped records; saturates at 16'hFFFF.
- err_o  out  3  sticky: [0] overflow, [1] order mismatch, [2] retire after halt.
- err_order_o  out  64  order value of the first mismatching record.

Behaviour:
- Reset values: all outputs 0, state RUN, expected order = FirstOrder, FIFO empty.
- Push: rvfi_valid_i with state RUN or HALT_DRAIN... not allowed; see state rules. Push is permitted only in RUN.
- Pop: out_valid_o && out_ready_i.
- Latency: a record pushed in cycle N appears at out_pkt_o in cycle N+1. There is no combinational bypass.
- out_pkt_o is stable while out_valid_o=1 and out_ready_i=0.
- Full FIFO with push and pop in the same cycle: push is accepted, no overflow.
- Full FIFO with push and no pop: the record is dropped, err_o[0] is set and drop_cnt_o increments.
- Order check on every accepted or dropped valid record:
  - If pkt.order != expected order, set err_o[1]. err_order_o captures pkt.order only on the first mismatch.
  - Expected order then becomes pkt.order+1, i.e. the tracker resyncs. Arithmetic is modulo 2^64.
- Pointers wrap modulo Depth. level_o = write count minus read count.
- FSM states: RUN, HALT_DRAIN, HALTED.
  - RUN: a pushed record with halt=1 moves the FSM to HALT_DRAIN.
  - HALT_DRAIN: records still drain to the consumer. When the FIFO becomes empty, move to HALTED.
  - HALTED: halted_o=1. resume_i moves the FSM to RUN next cycle.
- Any rvfi_valid_i in HALT_DRAIN or HALTED: the record is dropped, err_o[2] is set, drop_cnt_o increments. The order check still runs.
- flush_i (highest priority):
  - Next cycle: FIFO empty, state RUN, expected order = FirstOrder, out_valid_o=0.
  - err_o, err_order_o and drop_cnt_o are not cleared; only rst_i clears them.
  - A push in the flush cycle is discarded and not counted as dropped.
- resume_i together with flush_i: flush wins. resume_i outside HALTED is ignored.
- Reset mid-operation: takes effect immediately (asynchronous). Any in-flight handshake is abandoned.

Decomposition:
- Package rvfi_seq_pkg holds:
  - rvfi_retire_t packed struct and RvfiPktW = 382.
  - seq_state_e enum {RUN, HALT_DRAIN, HALTED}.
  - Error bit index constants ErrOvfl=0, ErrOrder=1, ErrPostHalt=2.
- Sub-module rvfi_seq_fifo: generic synchronous FIFO with registered output, push/pop/flush, full/empty/level.
- The top level holds the FSM, order tracker and error/counter logic.

Test Plan:
- Back-to-back retire, ready high: push orders 0..9 each cycle → out_pkt_o.order = 0..9 one cycle delayed; err_o = 0; level_o ≤ 1.
- Overflow, Depth=8, ready low: push orders 0..9 → level_o = 8; records 8 and 9 dropped; err_o[0] = 1; drop_cnt_o = 2. Then raise ready → orders 0..7 delivered in order.
- Full plus simultaneous pop: fill to 8, then push order 8 with ready high → no drop; level_o stays 8; err_o = 0.
- Order gap: push orders 0, 1, 3, 4 → err_o[1] = 1; err_order_o = 3. No further error after 4, because the tracker resynced.
- Halt sequence: push orders 0, 1, then order 2 with halt=1; ready held low 3 cycles. Push a valid in HALT_DRAIN → dropped, err_o[2] = 1. Raise ready → halted_o = 1 after record 2 is consumed. resume_i → RUN; next push accepted.
- Flush mid-stream: 5 entries queued, assert flush_i → next cycle level_o = 0, out_valid_o = 0, sticky errors retained. Push order FirstOrder → no order error.
